// File: rtl/nc_pkg.sv
// Shared definitions for the number converter ring datapath
// (compressor_ring / decompressor_ring).
//   ring_state_t : control states shared by the ring blocks
//   DATA_W       : packed word / value width
//   RING_W       : bit buffer width (two words)
//   width_mask   : low-order mask of W ones (W = 0..16)
package nc_pkg;

  localparam int DATA_W = 16;
  localparam int RING_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ring_state_t;

  // Shifting an all-ones word left by 16 yields zero, so W=16 gives all ones.
  function automatic logic [DATA_W-1:0] width_mask(input logic [4:0] w);
    return ~({DATA_W{1'b1}} << w);
  endfunction

endpackage

// File: rtl/decompressor_ring_bit_unpacker.sv
// bit_unpacker: bit buffer for the decompressor ring.
// Holds up to two words of unconsumed bits (LSB = oldest bit) and their count.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : empty the buffer (start of a new stream)
//   w          : value width 1..16
//   push       : append push_data above the bits still present after a pop
//   pop        : drop the oldest w bits
//   fill       : number of valid bits held (registered)
//   head       : oldest w bits, zero-extended
module bit_unpacker #(
  parameter int DATA_W = 16,
  parameter int FILL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [4:0]        w,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [FILL_W-1:0] fill,
  output logic [DATA_W-1:0] head
);
  import nc_pkg::*;

  logic [2*DATA_W-1:0] buf_reg, buf_next;
  logic [FILL_W-1:0]   fill_reg, fill_next;
  logic [2*DATA_W-1:0] shifted;
  logic [FILL_W-1:0]   fill_after;

  // Bits above fill are always zero (shifts bring in zeros and inserts land
  // exactly at fill), so an insert can simply be OR-ed in.
  always_comb begin
    shifted    = pop ? (buf_reg >> w) : buf_reg;
    fill_after = pop ? (fill_reg - FILL_W'(w)) : fill_reg;
    buf_next   = shifted;
    fill_next  = fill_after;
    if (push) begin
      buf_next  = shifted | ({{DATA_W{1'b0}}, push_data} << fill_after);
      fill_next = fill_after + FILL_W'(DATA_W);
    end
    if (clr) begin
      buf_next  = '0;
      fill_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_reg  <= '0;
      fill_reg <= '0;
    end else begin
      buf_reg  <= buf_next;
      fill_reg <= fill_next;
    end
  end

  assign fill = fill_reg;
  assign head = buf_reg[DATA_W-1:0] & width_mask(w);

endmodule

// File: rtl/decompressor_ring.sv
// decompressor_ring: unpacks a stream of 16-bit words carrying W-bit values
// (W = bitwidth_d+1, LSB-first, values may straddle words) into one
// zero-extended value per output handshake.
//   clk, rst                       : clock, asynchronous active-high reset
//   start, bitwidth_d, value_count : stream configuration, taken in IDLE
//   rcv_valid/rcv_data/rcv_last/rcv_ready : packed word input
//   trm_valid/trm_data/trm_last/trm_ready : unpacked value output
//   busy, done, err_underrun       : status
module decompressor_ring #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int FILL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        bitwidth_d,
  input  logic [CNT_W-1:0]  value_count,
  input  logic              rcv_valid,
  input  logic [DATA_W-1:0] rcv_data,
  input  logic              rcv_last,
  output logic              rcv_ready,
  output logic              trm_valid,
  output logic [DATA_W-1:0] trm_data,
  output logic              trm_last,
  input  logic              trm_ready,
  output logic              busy,
  output logic              done,
  output logic              err_underrun
);
  import nc_pkg::*;

  ring_state_t       state_reg, state_next;
  logic [4:0]        w_reg, w_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic              last_seen_reg, last_seen_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic [FILL_W-1:0] fill;
  logic [DATA_W-1:0] head;
  logic              accept, emit, push, clr;

  bit_unpacker #(
    .DATA_W (DATA_W),
    .FILL_W (FILL_W)
  ) u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .w         (w_reg),
    .push      (push),
    .push_data (rcv_data),
    .pop       (emit),
    .fill      (fill),
    .head      (head)
  );

  // Handshake terms depend only on registered state, so there is no path
  // from rcv_* to trm_* and rcv_ready never depends on trm_ready.
  assign trm_valid = (state_reg == RUN) && (fill >= FILL_W'(w_reg));
  assign rcv_ready = ((state_reg == RUN) && (fill <= FILL_W'(DATA_W))) ||
                     (state_reg == DRAIN);
  assign accept    = rcv_valid && rcv_ready;
  assign emit      = trm_valid && trm_ready;
  assign push      = accept && (state_reg == RUN);   // DRAIN discards words
  assign clr       = (state_reg == IDLE) && start;

  assign trm_data     = trm_valid ? head : '0;
  assign trm_last     = trm_valid && (remaining_reg == CNT_W'(1));
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign err_underrun = err_reg;

  always_comb begin
    state_next     = state_reg;
    w_next         = w_reg;
    remaining_next = remaining_reg;
    last_seen_next = last_seen_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          w_next         = 5'(bitwidth_d) + 5'd1;
          remaining_next = value_count;
          last_seen_next = 1'b0;
          err_next       = 1'b0;
          state_next     = (value_count == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept && rcv_last) last_seen_next = 1'b1;
        if (emit) begin
          remaining_next = remaining_reg - CNT_W'(1);
          if (remaining_reg == CNT_W'(1)) begin
            if (last_seen_reg || (accept && rcv_last)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = DRAIN;
            end
          end
        end else if (last_seen_reg && !trm_valid && (remaining_reg != '0)) begin
          // Stream ended with too few bits: leftover partial bits are dropped.
          err_next   = 1'b1;
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      DRAIN: begin
        if (accept && rcv_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      w_reg         <= '0;
      remaining_reg <= '0;
      last_seen_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      w_reg         <= w_next;
      remaining_reg <= remaining_next;
      last_seen_reg <= last_seen_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_decompressor_ring.sv
module tb_decompressor_ring;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  bitwidth_d;
  logic [31:0] value_count;
  logic        rcv_valid;
  logic [15:0] rcv_data;
  logic        rcv_last;
  logic        rcv_ready;
  logic        trm_valid;
  logic [15:0] trm_data;
  logic        trm_last;
  logic        trm_ready;
  logic        busy;
  logic        done;
  logic        err_underrun;

  decompressor_ring dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bitwidth_d   (bitwidth_d),
    .value_count  (value_count),
    .rcv_valid    (rcv_valid),
    .rcv_data     (rcv_data),
    .rcv_last     (rcv_last),
    .rcv_ready    (rcv_ready),
    .trm_valid    (trm_valid),
    .trm_data     (trm_data),
    .trm_last     (trm_last),
    .trm_ready    (trm_ready),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int done_n, emit_n, last_n, hold_n, waits;
  int first_emit, last_emit, last_cyc, done_cyc;
  bit saw_block;
  bit stall_prev;
  logic [15:0] data_prev;
  logic        last_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: scoreboard compare on every handshake, stability under stall.
  always @(negedge clk) begin
    if (!rst) begin
      if (trm_valid && trm_ready) begin
        exp_t e;
        check("sb_has_entry", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("trm_data", trm_data, e.data);
          check("trm_last", trm_last, e.last);
          $display("value %0h last %0b (expected %0h/%0b) cycle %0d", trm_data, trm_last, e.data, e.last, cyc);
        end
        emit_n++;
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
        if (trm_last) begin
          last_n++;
          last_cyc = cyc;
        end
      end
      if (stall_prev && trm_valid) begin
        hold_n++;
        check("hold_data", trm_data, data_prev);
        check("hold_last", trm_last, last_prev);
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (busy && rcv_valid && !rcv_ready) saw_block = 1'b1;
      stall_prev = trm_valid && !trm_ready;
      data_prev  = trm_data;
      last_prev  = trm_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic begin_test();
    sb.delete();
    done_n = 0; emit_n = 0; last_n = 0; hold_n = 0; waits = 0;
    first_emit = -1; last_emit = -1; last_cyc = -1; done_cyc = -1;
    saw_block = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] bw, input logic [31:0] cnt);
    bitwidth_d  = bw;
    value_count = cnt;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic expect_value(input logic [15:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    rcv_valid = 1'b1;
    rcv_data  = d;
    rcv_last  = l;
    forever begin
      @(negedge clk);
      if (rcv_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      waits++;
      if (n > 200) begin
        check("rcv_ready_timeout", 64'(rcv_ready), 1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    rcv_valid = 1'b0;
    rcv_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int n;
    n = 0;
    while (done_n == 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 64'(done_n), 1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 0);
    check({tag, "_err"}, err_underrun, exp_err);
    check({tag, "_idle"}, busy, 0);
    $display("%s: emitted %0d, done %0d, err %0b", tag, emit_n, done_n, err_underrun);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bitwidth_d = '0; value_count = '0;
    rcv_valid = 1'b0; rcv_data = '0; rcv_last = 1'b0; trm_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rcv_ready", rcv_ready, 0);
    check("rst_trm_valid", trm_valid, 0);
    check("rst_trm_data", trm_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err_underrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // W=4, single word, four nibbles 3,0,F,0 on consecutive cycles.
    begin_test();
    cfg(4'd3, 32'd4);
    expect_value(16'h3, 0); expect_value(16'h0, 0);
    expect_value(16'hF, 0); expect_value(16'h0, 1);
    send(16'h0f03, 1);
    wait_done("w4", 0);
    check("w4_span", 64'(last_emit - first_emit), 3);
    check("w4_done_lat", 64'(done_cyc - last_cyc), 1);

    // W=12, second value straddles the word boundary.
    begin_test();
    cfg(4'd11, 32'd2);
    expect_value(16'h0ABC, 0); expect_value(16'h0DEF, 1);
    send(16'hFABC, 0);
    send(16'h00DE, 1);
    wait_done("w12", 0);

    // W=16, full throughput, no input stalls.
    begin_test();
    cfg(4'd15, 32'd3);
    expect_value(16'h1, 0); expect_value(16'h2, 0); expect_value(16'h3, 1);
    send(16'h1, 0);
    send(16'h2, 0);
    send(16'h3, 1);
    check("w16_no_stall", 64'(waits), 0);
    wait_done("w16", 0);
    check("w16_span", 64'(last_emit - first_emit), 2);

    // Backpressure: W=4, trm_ready low for 5 cycles mid-stream.
    begin_test();
    cfg(4'd3, 32'd12);
    for (int i = 0; i < 12; i++) expect_value(16'(i), (i == 11));
    fork
      begin
        send(16'h3210, 0);
        send(16'h7654, 0);
        send(16'hBA98, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 trm_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 trm_ready = 1'b1;
      end
    join
    wait_done("bp", 0);
    check("bp_blocked", saw_block, 1);
    check("bp_hold_seen", 64'(hold_n >= 4), 1);
    check("bp_count", 64'(emit_n), 12);

    // Underrun: 8 values requested, only 4 delivered.
    begin_test();
    cfg(4'd3, 32'd8);
    expect_value(16'h1, 0); expect_value(16'h2, 0);
    expect_value(16'h3, 0); expect_value(16'h4, 0);
    send(16'h4321, 1);
    wait_done("underrun", 1);
    check("underrun_no_last", 64'(last_n), 0);

    // Overrun: 2 values, trailing words drained.
    begin_test();
    cfg(4'd3, 32'd2);
    expect_value(16'h1, 0); expect_value(16'h2, 1);
    send(16'h0021, 0);
    send(16'h1111, 0);
    send(16'h2222, 1);
    wait_done("overrun", 0);
    check("overrun_err_cleared", err_underrun, 0);

    // Asynchronous reset mid-RUN with a value pending.
    begin_test();
    trm_ready = 1'b0;
    cfg(4'd3, 32'd8);
    send(16'h5555, 0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", trm_valid, 1);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_trm_valid", trm_valid, 0);
    check("arst_trm_data", trm_data, 0);
    check("arst_rcv_ready", rcv_ready, 0);
    check("arst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    trm_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/decompressor_ring.md
Name: decompressor_ring

Overview:
- Receive-side counterpart of compressor_ring in the number converter datapath.
- Accepts a stream of packed 16-bit words in which values of reduced width W = bitwidth_d+1 are concatenated LSB-first, and values may straddle word boundaries.
- Emits one zero-extended 16-bit value per handshake, asserting trm_last on the final value of a configured count.
- Sits between the memory/link read side and the downstream converter.

Parameters:
- DATA_W, 16, width of input words and output values.
- CNT_W, 32, width of the value counter.
- FILL_W, 6, width of the bit-buffer fill counter (range 0..2*DATA_W).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; latches configuration, valid only in IDLE (ignored elsewhere)
- bitwidth_d  in  4  value width minus one (W = 1..16)
- value_count  in  CNT_W  number of values to emit
- rcv_valid  in  1  packed input word valid
- rcv_data  in  DATA_W  packed input word
- rcv_last  in  1  marks final packed word of the stream
- rcv_ready  out  1  input word accepted when rcv_valid & rcv_ready
- trm_valid  out  1  output value valid
- trm_data  out  DATA_W  unpacked value, bits [15:W] zero
- trm_last  out  1  high with the value_count-th value
- trm_ready  in  1  downstream accept
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on return to IDLE
- err_underrun  out  1  sticky; cleared by start

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; bit buffer=0; fill=0; remaining=0; all outputs 0.
- Internal state:
  - 2*DATA_W-bit shift buffer holding unconsumed bits, LSB = oldest bit.
  - fill = number of valid bits, 0..32.
  - W_r and remaining latched at start.
- IDLE:
  - rcv_ready=0, trm_valid=0.
  - On start: latch W_r=bitwidth_d+1 and remaining=value_count; clear err_underrun, buffer and fill.
  - If value_count==0, go to DRAIN; otherwise go to RUN.
- RUN:
  - rcv_ready = (fill <= 16).
  - trm_valid = (fill >= W_r).
  - trm_data = buffer[W_r-1:0], zero-extended; trm_last = (remaining==1).
  - Emit (trm_valid & trm_ready): shift buffer right by W_r; fill -= W_r; remaining -= 1.
  - Accept (rcv_valid & rcv_ready): write rcv_data at bit position fill (or fill-W_r if an emit happens in the same cycle); fill += 16.
  - Simultaneous accept and emit in one cycle is required; net fill change is 16-W_r.
  - Emitting the last value (remaining==1):
    - if rcv_last has already been accepted, or is accepted in the same cycle, go to IDLE and pulse done;
    - otherwise go to DRAIN.
  - Underrun: rcv_last has been accepted, fill < W_r, and remaining > 0. Set err_underrun, go to IDLE and pulse done. Any partial bits are discarded and trm_last is not asserted.
- DRAIN:
  - rcv_ready=1, trm_valid=0.
  - Discard words until rcv_last is accepted, then go to IDLE and pulse done.
  - Padding and extra values in discarded words are ignored.
- Latency: a value becomes visible the cycle after the word containing its last bit is accepted. There is no combinational path from rcv_* to trm_*.
- Backpressure: trm_data and trm_last are held stable while trm_valid & !trm_ready. rcv_ready depends only on registered fill, never on trm_ready.
- Padding: unused MSBs of the final packed word are zero from the compressor; the decompressor ignores their value.
- Throughput:
  - W=16: one value per cycle sustained.
  - W<16: input stalls while fill > 16.

Decomposition:
- Shared package nc_pkg holds:
  - typedef ring_state_t {IDLE, RUN, DRAIN};
  - constants DATA_W=16, RING_W=32;
  - function width_mask(W) returning a 16-bit mask, shared with compressor_ring.
- One natural sub-module: bit_unpacker. It holds the buffer, fill and shift/insert logic and exposes fill, head value, push and pop. The top level holds the FSM and counters.

Test Plan:
- W=4 (bitwidth_d=3), value_count=4, one word 16'h0f03 with rcv_last, trm_ready=1 → trm_data 3,0,F,0 on consecutive cycles; trm_last with the 4th value; done one cycle later; err_underrun=0.
- W=12 (bitwidth_d=11), value_count=2, words 16'hFABC then 16'h00DE (last) → 12'hABC, then 12'hDEF (straddled) with trm_last; the upper nibble of trm_data is zero.
- W=16, value_count=3, words 1,2,3 back-to-back, last on 3 → outputs 1,2,3 with one value per cycle and rcv_ready continuously 1.
- Backpressure: W=4, hold trm_ready=0 for 5 cycles mid-stream → trm_data stable; rcv_ready drops when fill > 16; no value lost or duplicated.
- Underrun: W=4, value_count=8, one word 16'h4321 with rcv_last → 1,2,3,4 emitted with no trm_last; err_underrun=1; done pulses; state IDLE.
- Overrun and reset: value_count=2 with W=4, three words, the 3rd with last → 2 values, trm_last on the 2nd, remaining words drained, done. Separately, assert rst mid-RUN → all outputs 0 immediately, state IDLE.
